// File: rtl/b002_encoder.sv
// IRIG-B002 pulse-width time-code generator: one 100-bit frame per second from AXI-Stream.
// Optional external PPS alignment is enabled with B002_EXT_PPS_EN.
module b002_encoder #(
  parameter int BIT_PERIOD = 500000,
  parameter int WIDTH_0    = 100000,
  parameter int WIDTH_1    = 250000,
  parameter int WIDTH_P    = 400000,
  parameter int CNT_W      = 20
) (
  input  logic         clk_50MHz,
  input  logic         resetn,
  input  logic         enable,
  input  logic [99:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic         irig_out,
  output logic         frame_start,
  output logic [6:0]   bit_index,
  output logic         underrun
`ifdef B002_EXT_PPS_EN
  ,
  input  logic         pps_in,
  output logic         pps_err
`endif
);

  localparam logic [CNT_W-1:0] LP_BP_M1 = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_W0    = CNT_W'(WIDTH_0);
  localparam logic [CNT_W-1:0] LP_W1    = CNT_W'(WIDTH_1);
  localparam logic [CNT_W-1:0] LP_WP    = CNT_W'(WIDTH_P);

`ifdef B002_EXT_PPS_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_PPS} t_state;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} t_state;
`endif

  t_state           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_bit;
  logic [99:0]      r_hold;
  logic             r_hold_full;
  logic [99:0]      r_active;
  logic             r_irig;
  logic             r_frame_start;
  logic             r_underrun;

  logic             w_xfer;
  logic             w_bit_end;
  logic             w_last_bit;
  logic             w_boundary;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_cnt_inc;

  function automatic logic [CNT_W-1:0] f_width(input logic [6:0] k, input logic [99:0] frame);
    if ((k == 7'd0) || ((k % 7'd10) == 7'd9)) return LP_WP;
    else if (frame[k])                        return LP_W1;
    else                                      return LP_W0;
  endfunction

`ifdef B002_EXT_PPS_EN
  logic r_pps_meta;
  logic r_pps_sync;
  logic r_pps_prev;
  logic r_pps_err;
  logic w_pps_edge;

  always_ff @(posedge clk_50MHz or negedge resetn) begin
    if (!resetn) begin
      r_pps_meta <= 1'b0;
      r_pps_sync <= 1'b0;
      r_pps_prev <= 1'b0;
    end else begin
      r_pps_meta <= pps_in;
      r_pps_sync <= r_pps_meta;
      r_pps_prev <= r_pps_sync;
    end
  end

  assign w_pps_edge = r_pps_sync & ~r_pps_prev;
  assign pps_err    = r_pps_err;
`endif

  assign w_xfer     = s_axis_tvalid & ~r_hold_full;
  assign w_bit_end  = (r_cnt == LP_BP_M1);
  assign w_last_bit = (r_bit == 7'd99);
  assign w_width    = f_width(r_bit, r_active);
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_comb begin
    w_boundary = 1'b0;
`ifdef B002_EXT_PPS_EN
    // A PPS edge in the low phase of bit 99 cuts that bit short and starts the frame.
    if ((r_state == S_WAIT_PPS) && w_pps_edge)
      w_boundary = 1'b1;
    else if ((r_state == S_RUN) && w_last_bit && enable && w_pps_edge && (r_cnt >= LP_WP))
      w_boundary = 1'b1;
`else
    if ((r_state == S_IDLE) && enable)
      w_boundary = 1'b1;
    else if ((r_state == S_RUN) && w_bit_end && w_last_bit && enable)
      w_boundary = 1'b1;
`endif
  end

  always_ff @(posedge clk_50MHz or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_active      <= '0;
      r_irig        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
`ifdef B002_EXT_PPS_EN
      r_pps_err     <= 1'b0;
`endif
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
`ifdef B002_EXT_PPS_EN
      r_pps_err     <= 1'b0;
`endif

      // A word arriving on the boundary cycle while empty is kept for the next frame.
      if (w_boundary && r_hold_full) begin
        r_active    <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_xfer) begin
        r_hold      <= s_axis_tdata;
        r_hold_full <= 1'b1;
      end
      if (w_boundary) r_underrun <= ~r_hold_full;

      if (w_boundary) begin
        r_state       <= S_RUN;
        r_cnt         <= '0;
        r_bit         <= '0;
        r_irig        <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_irig <= 1'b0;
`ifdef B002_EXT_PPS_EN
            if (enable) r_state <= S_WAIT_PPS;
`endif
          end
`ifdef B002_EXT_PPS_EN
          S_WAIT_PPS: begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_irig <= 1'b0;
            if (!enable) r_state <= S_IDLE;
          end
`endif
          S_RUN: begin
`ifdef B002_EXT_PPS_EN
            r_pps_err <= w_pps_edge;
`endif
            if (w_bit_end) begin
              r_cnt <= '0;
              if (w_last_bit) begin
                r_bit  <= '0;
                r_irig <= 1'b0;
`ifdef B002_EXT_PPS_EN
                r_state <= enable ? S_WAIT_PPS : S_IDLE;
`else
                r_state <= S_IDLE;
`endif
              end else begin
                r_bit  <= r_bit + 7'd1;
                r_irig <= 1'b1;
              end
            end else begin
              r_cnt  <= w_cnt_inc;
              r_irig <= (w_cnt_inc < w_width);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s_axis_tready = ~r_hold_full;
  assign irig_out      = r_irig;
  assign frame_start   = r_frame_start;
  assign bit_index     = r_bit;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_b002_encoder.sv
// Self-checking bench for b002_encoder with a shortened bit period (50 clocks).
// Expected pulse widths are queued per frame and popped as each IRIG pulse is measured.
module tb_b002_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [99:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        irig;
  logic        fs;
  logic [6:0]  bidx;
  logic        ur;
`ifdef B002_EXT_PPS_EN
  logic        pps;
  logic        perr;
`endif

  always #5 clk = ~clk;

  b002_encoder #(
    .BIT_PERIOD(50),
    .WIDTH_0(10),
    .WIDTH_1(25),
    .WIDTH_P(40),
    .CNT_W(20)
  ) dut (
    .clk_50MHz(clk),
    .resetn(resetn),
    .enable(enable),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .irig_out(irig),
    .frame_start(fs),
    .bit_index(bidx),
    .underrun(ur)
`ifdef B002_EXT_PPS_EN
    ,
    .pps_in(pps),
    .pps_err(perr)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_fs = 0, n_ur = 0, n_fs_bad = 0, n_perr = 0;
  int last_fs = 0, prev_fs = 0;
  int exp_q[$];
  logic [99:0] dec_word;
  logic [99:0] w_one_two_three;
  logic [99:0] w_all;
  logic [99:0] w_all_dec;
  int hc, fs0, ur0, t, p0, p1;

  always @(negedge clk) begin
    cyc++;
    if (fs === 1'b1) begin
      n_fs++;
      prev_fs = last_fs;
      last_fs = cyc;
      if (!(irig === 1'b1 && bidx === 7'd0)) n_fs_bad++;
    end
    if (ur === 1'b1) n_ur++;
`ifdef B002_EXT_PPS_EN
    if (perr === 1'b1) n_perr++;
`endif
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [99:0] w);
    for (int k = 0; k < 100; k++)
      exp_q.push_back((k == 0 || k % 10 == 9) ? 40 : (w[k] ? 25 : 10));
  endfunction

  task automatic push_word(input logic [99:0] w);
    chk("tready_pre_push", tready, 1);
    tdata  = w;
    tvalid = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    chk("tready_post_push", tready, 0);
  endtask

  // Measures n consecutive high pulses and compares each width with the scoreboard.
  task automatic check_bits(input int n);
    int tt, w, e, k;
    for (int i = 0; i < n; i++) begin
      tt = 0;
      while (irig !== 1'b1 && tt < 200) begin
        @(negedge clk);
        tt++;
      end
      if (tt >= 200) chk("rise_timeout", irig, 1);
      k = int'(bidx);
      w = 0;
      while (irig === 1'b1 && w < 100) begin
        w++;
        @(negedge clk);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk($sformatf("width_bit%0d", k), w, e);
      if (k < 100) dec_word[k] = (w >= 18 && w < 33);
    end
  endtask

`ifdef B002_EXT_PPS_EN
  task automatic pulse_pps(output int at);
    at  = cyc;
    pps = 1'b1;
    repeat (3) @(negedge clk);
    pps = 1'b0;
  endtask
`endif

  initial begin
    w_one_two_three = 100'h0E;
    w_all = '1;
    w_all_dec = '1;
    for (int k = 0; k < 100; k++)
      if (k == 0 || k % 10 == 9) w_all_dec[k] = 1'b0;
    dec_word = '0;

    resetn = 1'b0;
    enable = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
`ifdef B002_EXT_PPS_EN
    pps = 1'b0;
`endif
    #1;
    chk("rst_irig", irig, 0);
    chk("rst_tready", tready, 1);
    chk("rst_frame_start", fs, 0);
    chk("rst_bit_index", bidx, 0);
    chk("rst_underrun", ur, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

`ifndef B002_EXT_PPS_EN
    // Frame 1: bits 1..3 set
    push_word(w_one_two_three);
    push_frame(w_one_two_three);
    enable = 1'b1;
    check_bits(10);
    chk("tready_after_load", tready, 1);
    push_word(w_all);
    push_frame(w_all);
    check_bits(90);
    chk("fs_count_frame1", n_fs, 1);
    chk("ur_count_frame1", n_ur, 0);

    // Frame 2: all ones, decoded like the reader
    dec_word = '0;
    check_bits(100);
    chk("decode_all_ones", dec_word, w_all_dec);
    chk("ur_count_frame2", n_ur, 0);

    // Frame 3: nothing queued, repeats previous word
    push_frame(w_all);
    check_bits(1);
    chk("ur_count_frame3", n_ur, 1);
    chk("frame_length", last_fs - prev_fs, 5000);
    chk("tready_underrun", tready, 1);
    check_bits(49);
    enable = 1'b0;
    check_bits(50);
    hc = 0;
    repeat (300) begin
      @(negedge clk);
      if (irig === 1'b1) hc++;
    end
    chk("idle_high_cycles", hc, 0);
    chk("idle_bit_index", bidx, 0);
    chk("fs_total", n_fs, 3);
    chk("fs_alignment_errors", n_fs_bad, 0);

    // Reset in the high phase of bit 37
    push_word(w_all);
    push_frame(w_all);
    enable = 1'b1;
    check_bits(37);
    push_word(w_one_two_three);
    t = 0;
    while (irig !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("bit37_index", bidx, 37);
    repeat (12) @(negedge clk);
    chk("pre_reset_irig", irig, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_irig", irig, 0);
    chk("async_rst_tready", tready, 1);
    chk("async_rst_bit_index", bidx, 0);
    exp_q.delete();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    fs0 = n_fs;
    ur0 = n_ur;
    push_frame('0);
    enable = 1'b1;
    check_bits(10);
    chk("restart_fs", n_fs, fs0 + 1);
    chk("restart_underrun", n_ur, ur0 + 1);
    enable = 1'b0;
`else
    push_word(w_one_two_three);
    push_frame(w_one_two_three);
    enable = 1'b1;
    @(negedge clk);
    pulse_pps(p0);
    check_bits(21);
    pulse_pps(t);
    check_bits(79);
    chk("pps_err_count", n_perr, 1);
    chk("pps_fs_count1", n_fs, 1);
    hc = 0;
    while (cyc < p0 + 5100) begin
      @(negedge clk);
      if (irig === 1'b1) hc++;
    end
    chk("pps_gap_low", hc, 0);
    push_frame(w_one_two_three);
    pulse_pps(p1);
    check_bits(1);
    chk("pps_fs_interval", last_fs - prev_fs, p1 - p0);
    chk("pps_fs_interval_5100", last_fs - prev_fs, 5100);
    chk("pps_underrun", n_ur, 1);
    chk("pps_fs_alignment", n_fs_bad, 0);
    enable = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/b002_encoder.md
Name: b002_encoder

Overview:
- IRIG-B002 (DC level-shift, pulse-width coded) time-code generator.
- Accepts one 100-bit frame per second on an AXI-Stream slave and emits the matching pulse train on irig_out.
- Runs on the 50 MHz fabric clock. Serves as the stimulus and reference source for the IRIG reader path and drives external IRIG slaves.
- Bit k of the frame word maps to frame position k (k = 0..99), the same layout the reader produces.

Parameters:
- BIT_PERIOD, 500000: clocks per bit (10 ms).
- WIDTH_0, 100000: high time of a "0" (2 ms).
- WIDTH_1, 250000: high time of a "1" (5 ms).
- WIDTH_P, 400000: high time of a position marker (8 ms).
- CNT_W, 20: width of the in-bit cycle counter. Must satisfy 2^CNT_W > BIT_PERIOD.

Ports:
- clk_50MHz  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  level; start/continue generation.
- s_axis_tdata  in  100  frame word; bit k = position k.
- s_axis_tvalid  in  1  frame word valid.
- s_axis_tready  out  1  holding register empty.
- irig_out  out  1  registered IRIG-B002 level.
- frame_start  out  1  one-cycle pulse coincident with the Pr rising edge (bit 0).
- bit_index  out  7  current position, 0..99.
- underrun  out  1  one-cycle pulse: frame started with no new word queued.

Behaviour:
- Reset (asynchronous, resetn low): all outputs take their reset values immediately.
  - irig_out=0, frame_start=0, bit_index=0, underrun=0, s_axis_tready=1.
  - State=IDLE, cycle counter=0, holding register empty, active frame register=0.
- Reset mid-frame aborts the frame; no completion is attempted.
- Holding register:
  - Single-entry.
  - s_axis_tready = ~hold_full.
  - A transfer occurs when tvalid & tready; the word is stored and hold_full is set.
  - A new word is accepted at any time while empty, including during a frame.
- Frame boundary: the cycle at which bit 0 begins.
  - If hold_full: active_frame <= hold, hold_full cleared. tready rises the next cycle.
  - Else: active_frame is reused unchanged and underrun pulses.
  - A transfer in the same cycle as the boundary while empty is not used by this frame. It is held for the next frame, and underrun still pulses.
- Bit type for position k:
  - k==0 or k mod 10 == 9 → P.
  - Otherwise active_frame[k] selects 1 or 0.
  - Frame word bits at P positions are ignored.
- Bit waveform: irig_out is high for counter 0..W-1 and low for W..BIT_PERIOD-1, where W is WIDTH_0, WIDTH_1 or WIDTH_P.
  - The counter wraps at BIT_PERIOD-1 to 0 and bit_index increments.
  - bit_index wraps 99 → 0, which is a frame boundary.
  - irig_out is registered and aligned to the counter value with a fixed 1-cycle latency.
- State machine:
  - IDLE: irig_out=0, counter held 0. When enable=1, go to RUN; the frame boundary occurs in that cycle. irig_out rises and frame_start pulses on the next cycle.
  - RUN: generate bits continuously. At the end of bit 99:
    - enable=1 → next frame, no gap.
    - enable=0 → return to IDLE.
  - Deasserting enable mid-frame never truncates the frame.
- Timing: frame length is exactly 100*BIT_PERIOD clocks, and consecutive frame_start pulses are 50,000,000 cycles apart.
- Simultaneous events: a reset assertion overrides everything. Enable toggling within a frame has no effect until the end of bit 99.

Optional Feature:
- Macro: B002_EXT_PPS_EN.
- Defined:
  - Adds input port pps_in (1 bit), synchronised by 2 flip-flops, rising-edge detected.
  - Adds output pps_err (1-cycle pulse).
  - Adds state WAIT_PPS, which holds irig_out=0.
  - IDLE with enable=1 goes to WAIT_PPS. The end of bit 99 with enable=1 also goes to WAIT_PPS.
  - A detected PPS edge in WAIT_PPS causes the frame boundary; the rising edge follows 1 cycle later.
  - A PPS edge arriving during bit 99 after its high phase truncates the low phase and starts the frame immediately.
  - A PPS edge at any other point in RUN pulses pps_err and is ignored.
- Undefined: no pps_in/pps_err ports, free-running timing as above.

Test Plan:
- Use overrides BIT_PERIOD=50, WIDTH_0=10, WIDTH_1=25, WIDTH_P=40 for all scenarios.
- Push word with bits 1,2,3 = 1 and the rest 0, then enable=1:
  - irig_out high widths are 40,25,25,25,10,10,10,10,10,40 over bits 0..9.
  - frame_start pulses once.
  - The frame is 5000 cycles long.
- Word with all ones, including P positions: positions 0,9,19,…,99 are width 40 and all others width 25. Compare against the reader decode, which yields the same 100-bit word with P positions 0.
- No second word pushed: the second frame repeats the first, underrun pulses at the cycle-5000 boundary, and s_axis_tready stays 1.
- Deassert enable at bit 50: the frame completes through bit 99, irig_out stays 0 afterwards, state is IDLE, and bit_index=0.
- Assert resetn=0 at bit 37, counter 12: irig_out=0 and tready=1 with no clock edge required. After release with enable=1, the next frame restarts at bit 0.
- B002_EXT_PPS_EN defined:
  - PPS edge every 5100 cycles: 100-cycle low gap before each frame_start.
  - PPS injected at bit 20: pps_err pulses and the frame is unaffected.
